// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: arbitrates mispredict / eret / interrupt / halt
// events and load-use hazards into PC, IF/ID and ID/EX stall/flush controls.
module pipe_ctrl #(
  parameter logic [31:0] INT_VECTOR = 32'h0000_0400,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mispredict,
  input  logic [31:0]      ex_target,
  input  logic             ex_eret,
  input  logic             ex_halt,
  input  logic             go,
  input  logic             int_req,
  input  logic [31:0]      resume_pc,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             int_ack,
  output logic             halted,
  output logic [1:0]       state,
  output logic [31:0]      epc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTED  = 2'd1,
    ST_INT_SVC = 2'd2
  } state_t;

  state_t           r_state;
  state_t           r_saved_state;
  state_t           w_next_state;
  logic [31:0]      r_epc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_hz;
  logic w_active;
  logic w_int_ok;
  logic w_take_mis;
  logic w_take_eret;
  logic w_take_int;
  logic w_take_halt;
  logic w_take_stall;
  logic w_redirect;

  assign w_hz = ex_memread && (ex_rd != 5'd0) &&
                ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  // Event arbitration; each w_take_* is one-hot and already masked by rst/HALTED.
  assign w_active     = !rst && (r_state != ST_HALTED);
  assign w_int_ok     = int_req && (r_state == ST_RUN);
  assign w_take_mis   = w_active && ex_mispredict;
  assign w_take_eret  = w_active && !ex_mispredict && ex_eret;
  assign w_take_int   = w_active && !ex_mispredict && !ex_eret && w_int_ok;
  assign w_take_halt  = w_active && !ex_mispredict && !ex_eret && !w_int_ok && ex_halt;
  assign w_take_stall = w_active && !ex_mispredict && !ex_eret && !w_int_ok && !ex_halt && w_hz;
  assign w_redirect   = w_take_mis || w_take_eret || w_take_int;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_HALTED: begin
        if (go) w_next_state = r_saved_state;
      end
      ST_RUN, ST_INT_SVC: begin
        if (w_take_eret)      w_next_state = ST_RUN;
        else if (w_take_int)  w_next_state = ST_INT_SVC;
        else if (w_take_halt) w_next_state = ST_HALTED;
      end
      default: w_next_state = ST_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    int_ack     = 1'b0;
    halted      = 1'b0;
    if (!rst) begin
      if (r_state == ST_HALTED) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
        halted     = 1'b1;
      end else if (w_redirect) begin
        redirect   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        int_ack    = w_take_int;
        if (w_take_mis)       redirect_pc = ex_target;
        else if (w_take_eret) redirect_pc = r_epc;
        else                  redirect_pc = INT_VECTOR;
      end else if (w_take_halt) begin
        idex_flush = 1'b1;
      end else if (w_take_stall) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  // Saved state, EPC and saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_saved_state <= ST_RUN;
      r_epc         <= 32'd0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      if (w_take_halt) r_saved_state <= r_state;
      if (w_take_int)  r_epc <= resume_pc;
      if (w_take_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_redirect && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign state     = r_state;
  assign epc       = r_epc;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage dynamic-prediction CPU.
- Generates the stall, flush and bubble controls for the PC register, the IF/ID register and the ID/EX register, plus the PC redirect.
- Arbitrates between four event sources: EX-stage branch mispredict, eret, external interrupt, and halt/resume.
- Also detects load-use hazards, holds EPC, and keeps stall/flush performance counters.

Parameters:
INT_VECTOR, 32'h0000_0400, PC loaded when an interrupt is accepted
CNT_W, 32, width of stall_cnt and flush_cnt

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_memread  in  1  EX instruction is a load
ex_rd  in  5  destination register of the EX instruction
ex_mispredict  in  1  EX branch resolved differently from prediction
ex_target  in  32  correct next PC for the mispredicted branch
ex_eret  in  1  eret in EX
ex_halt  in  1  halt syscall in EX
go  in  1  resume request while halted
int_req  in  1  level interrupt request
resume_pc  in  32  PC of oldest instruction not yet in EX
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID
ifid_flush  out  1  clear IF/ID
idex_flush  out  1  insert bubble into ID/EX
redirect  out  1  load PC from redirect_pc
redirect_pc  out  32  redirect target
int_ack  out  1  one-cycle pulse, interrupt accepted
halted  out  1  state == HALTED
state  out  2  RUN=0, HALTED=1, INT_SVC=2
epc  out  32  saved exception PC
stall_cnt  out  CNT_W  load-use stall cycles
flush_cnt  out  CNT_W  redirect cycles

Behaviour:
- Registered state: state, saved_state, epc, stall_cnt, flush_cnt.
- Reset values: state=RUN, saved_state=RUN, epc=0, both counters 0.
- Control outputs are combinational from inputs and state, acting in the same cycle. While rst=1 every output is 0 and state reads 0.
- Load-use hazard (hz) = ex_memread & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
- Per-cycle priority, highest first:
  1) Mispredict: ex_mispredict, state!=HALTED.
     - Outputs: redirect=1, redirect_pc=ex_target, ifid_flush=1, idex_flush=1.
     - State unchanged.
  2) Eret: ex_eret, state!=HALTED.
     - Outputs: redirect=1, redirect_pc=epc, ifid_flush=1, idex_flush=1.
     - Next state RUN. An eret in RUN is still honoured.
  3) Interrupt: int_req, state==RUN.
     - Outputs: redirect=1, redirect_pc=INT_VECTOR, ifid_flush=1, idex_flush=1, int_ack=1.
     - epc<=resume_pc; next state INT_SVC.
  4) Halt: ex_halt, state is RUN or INT_SVC.
     - saved_state<=state; next state HALTED.
     - Same cycle: idex_flush=1, no other control asserted.
  5) Load-use: hz, state is RUN or INT_SVC.
     - Outputs: pc_stall=1, ifid_stall=1, idex_flush=1.
     - stall_cnt increments.
- HALTED state:
  - pc_stall=1, ifid_stall=1, idex_flush=1 every cycle; halted=1.
  - ex_mispredict, ex_eret, int_req, ex_halt and hz are ignored.
  - go=1 returns to saved_state on the next edge. go has no effect outside HALTED.
- INT_SVC masks int_req. A deferred or masked interrupt is taken only if int_req is still high in a RUN cycle; the requester holds the level until int_ack.
- Flush suppresses stall: in a cycle with any redirect, pc_stall=ifid_stall=0 even if hz=1.
- flush_cnt increments in every cycle with redirect=1.
- Both counters saturate at all-ones; no wrap-around.
- Reset asserted mid-operation (any state, counters non-zero) returns immediately to reset values. No pending event survives.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs=5 for 1 cycle -> pc_stall=ifid_stall=idex_flush=1 that cycle, stall_cnt 0->1. Same with ex_rd=0 -> no stall.
- Mispredict plus hazard: ex_mispredict=1, ex_target=32'h0000_0040, hz=1 -> redirect=1, redirect_pc=0x40, ifid_flush=idex_flush=1, pc_stall=0, flush_cnt+1, stall_cnt unchanged.
- Interrupt round trip: RUN, int_req=1, resume_pc=0x100 -> int_ack pulse, redirect_pc=0x400, epc=0x100, state=2. Hold int_req -> no second ack. ex_eret=1 -> redirect_pc=0x100, state=0, then int_req still high -> ack again.
- Interrupt vs mispredict same cycle: int_req=1 and ex_mispredict=1 -> redirect_pc=ex_target, int_ack=0. Next cycle int_ack=1.
- Halt from INT_SVC: ex_halt=1 -> HALTED, halted=1, all stall/bubble outputs high for 10 cycles. int_req ignored. go=1 -> state=2.
- Counter saturation and reset: CNT_W=4, hold hz for 20 cycles -> stall_cnt stops at 15. Assert rst mid-halt -> state=0, counters 0, outputs 0 immediately.
